latch_classifier: RTL and testbench

LATCH_CLASSIFIER -- requirements
Module: latch_classifier

---
 rtl/latch_classifier.sv | 125 ++++++++++++
 tb/tb_latch_classifier.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_classifier.sv
// Drives the four (enable, data) vectors into an external latch and classifies its response.
// Define LATCH_CLASSIFIER_SYNC_EN to add a two-flop synchroniser on probe_q (hold grows by 2).
module latch_classifier #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       probe_en,
    output logic       probe_d,
    input  logic       probe_q,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       active_high,
    output logic       mismatch,
    output logic [3:0] samples
);

`ifdef LATCH_CLASSIFIER_SYNC_EN
    localparam int unsigned HOLD = SETTLE_CYCLES + 2;

    logic sync_meta;
    logic sync_out;
    logic q_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= probe_q;
            sync_out  <= sync_meta;
        end
    end

    assign q_cap = sync_out;
`else
    localparam int unsigned HOLD = SETTLE_CYCLES;

    logic q_cap;

    assign q_cap = probe_q;
`endif

    // Widen only when the synchronised hold reaches 17 cycles.
    localparam int unsigned CntW = (HOLD > 16) ? 5 : 4;
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DECIDE, DONE} state_t;

    state_t          state;
    logic [1:0]      idx;
    logic [CntW-1:0] hold_cnt;
    logic            is_high;
    logic            is_low;

    assign is_high = (samples[0] == samples[1]) && !samples[2] && samples[3];
    assign is_low  = (samples == 4'b1110);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 2'd0;
            hold_cnt     <= '0;
            probe_en     <= 1'b0;
            probe_d      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            active_high  <= 1'b0;
            mismatch     <= 1'b0;
            samples      <= 4'b0000;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= APPLY;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        active_high  <= 1'b0;
                        mismatch     <= 1'b0;
                        samples      <= 4'b0000;
                        idx          <= 2'd0;
                        hold_cnt     <= '0;
                        probe_en     <= 1'b0;
                        probe_d      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (hold_cnt == HoldLast) begin
                        samples[idx] <= q_cap;
                        hold_cnt     <= '0;
                        if (idx == 2'd3) begin
                            state <= DECIDE;
                        end else begin
                            idx                 <= idx + 2'd1;
                            {probe_en, probe_d} <= idx + 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    active_high  <= is_high;
                    mismatch     <= !(is_high || is_low);
                    state        <= DONE;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    probe_en     <= 1'b0;
                    probe_d      <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_classifier.sv
// Scoreboard bench for latch_classifier: a behavioural latch drives probe_q and a
// vector-walk reference model predicts samples, classification and done latency.
module tb_latch_classifier;

    localparam int unsigned SETTLE = 2;
`ifdef LATCH_CLASSIFIER_SYNC_EN
    localparam int unsigned HOLD = SETTLE + 2;
`else
    localparam int unsigned HOLD = SETTLE;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       probe_en;
    logic       probe_d;
    logic       probe_q;
    logic       busy;
    logic       done;
    logic       result_valid;
    logic       active_high;
    logic       mismatch;
    logic [3:0] samples;

    latch_classifier #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .probe_en     (probe_en),
        .probe_d      (probe_d),
        .probe_q      (probe_q),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .active_high  (active_high),
        .mismatch     (mismatch),
        .samples      (samples)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Device under test: 0 = active-high latch, 1 = active-low latch, 2 = lookup on (en,d)
    int         mode = 1;
    logic       init_val = 1'b0;
    logic       load = 1'b0;
    logic [3:0] tbl = 4'b0000;
    logic       lq = 1'b0;

    always @(*) begin
        case (mode)
            0: if (probe_en) lq = probe_d; else if (load) lq = init_val;
            1: if (!probe_en) lq = probe_d;
            default: lq = tbl[{probe_en, probe_d}];
        endcase
    end
    assign probe_q = lq;

    typedef struct {
        logic [3:0]  s;
        logic        ah;
        logic        mm;
        int unsigned e0;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
    endtask

    function automatic exp_t model(input int m, input logic q0, input logic [3:0] t);
        exp_t e;
        logic q;
        logic en;
        logic d;
        logic hi;
        logic lo;
        q = q0;
        e.s = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            en = (v >= 2);
            d  = (v % 2 == 1);
            if (m == 0) begin
                if (en) q = d;
            end else if (m == 1) begin
                if (!en) q = d;
            end else begin
                q = t[v];
            end
            e.s[v] = q;
        end
        hi = (e.s[0] == e.s[1]) && (e.s[2] == 1'b0) && (e.s[3] == 1'b1);
        lo = (e.s == 4'b1110);
        e.ah = hi;
        e.mm = !(hi || lo);
        e.e0 = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                got = sb.pop_front();
                chk("samples", {28'd0, samples}, {28'd0, got.s});
                chk("active_high", {31'd0, active_high}, {31'd0, got.ah});
                chk("mismatch", {31'd0, mismatch}, {31'd0, got.mm});
                chk("result_valid_at_done", {31'd0, result_valid}, 32'd1);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("probes_at_done", {30'd0, probe_en, probe_d}, 32'd0);
                chk("latency", cyc - got.e0 + 1, 4 * HOLD + 2);
            end
        end
    end

    task automatic setup(input int m, input logic q0, input logic [3:0] t);
        mode = m;
        tbl = t;
        init_val = q0;
        load = 1'b1;
        #1 load = 1'b0;
    endtask

    task automatic push_exp(input int m, input logic [3:0] t);
        exp_t e;
        e = model(m, lq, t);
        e.e0 = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    task automatic run(input int m, input logic q0, input logic [3:0] t, input bit repulse);
        @(negedge clk);
        setup(m, q0, t);
        push_exp(m, t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {30'd0, busy, result_valid}, 32'd2);
        if (repulse) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain("done_timeout");
        repeat (3) @(negedge clk);
        chk("result_held", {26'd0, result_valid, busy, samples}, {26'd0, 2'b10, got.s});
    endtask

    initial begin
        #2;
        chk("reset_outputs", {21'd0, probe_en, probe_d, busy, done, result_valid, active_high,
            mismatch, samples}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {29'd0, busy, done, result_valid}, 32'd0);

        run(0, 1'b0, 4'b0000, 1'b0);
        chk("ah_q0_samples", {28'd0, samples}, 32'h8);
        run(1, 1'b0, 4'b0000, 1'b0);
        chk("al_samples", {28'd0, samples, active_high, mismatch}, {26'd0, 4'b1110, 2'b00});
        run(0, 1'b1, 4'b0000, 1'b0);
        chk("ah_q1_samples", {28'd0, samples, active_high}, {27'd0, 4'b1011, 1'b1});
        run(2, 1'b0, 4'b0000, 1'b0);
        chk("stuck0", {28'd0, samples, mismatch}, {27'd0, 4'b0000, 1'b1});
        run(0, 1'b0, 4'b0000, 1'b1);

        // Abandon a run with reset, then restart on the first edge after release.
        @(negedge clk);
        setup(0, 1'b0, 4'b0000);
        push_exp(0, 4'b0000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {21'd0, probe_en, probe_d, busy, done, result_valid,
            active_high, mismatch, samples}, 32'd0);
        sb.delete();
        @(negedge clk);
        setup(0, 1'b0, 4'b0000);
        @(negedge clk);
        push_exp(0, 4'b0000);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_drain("restart_timeout");

        for (int r = 0; r < 16; r++) begin
            run($urandom_range(0, 2), 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
